// File: rtl/writeback_port_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NUM_UNITS
// writeback sources; the winner is presented one cycle later as a registered commit.
module writeback_port_arbiter #(
   parameter int NUM_UNITS  = 4,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 64,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 init_clear,
   input  logic [NUM_UNITS-1:0]                 unit_valid,
   input  logic [NUM_UNITS-1:0][AW-1:0]         unit_phys_addr,
   input  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] unit_data,
   output logic [NUM_UNITS-1:0]                 unit_ack,
   output logic                                 commit_valid,
   output logic [AW-1:0]                        commit_phys_addr,
   output logic [DATA_WIDTH-1:0]                commit_data,
   output logic                                 inflight_commit,
   output logic [AW-1:0]                        inflight_commit_addr
);

   localparam int PW = $clog2(NUM_UNITS);

   // Handshake: a unit holds unit_valid/addr/data stable until unit_ack is high in
   // the same cycle; the transfer happens on that edge and a new request may follow.
   logic [PW-1:0]        ptr;
   logic [NUM_UNITS-1:0] upper_req;
   logic                 hit_hi;
   logic                 hit_lo;
   logic [PW-1:0]        win_hi;
   logic [PW-1:0]        win_lo;
   logic [PW-1:0]        winner;
   logic                 grant_any;
   logic [PW-1:0]        ptr_next;
   logic [AW-1:0]        winner_addr;
   logic [DATA_WIDTH-1:0] winner_data;

   // Two-pass search: requesters at or above ptr first, then wrap to the lowest.
   always_comb begin
      upper_req = '0;
      hit_hi    = 1'b0;
      hit_lo    = 1'b0;
      win_hi    = '0;
      win_lo    = '0;
      for (int j = 0; j < NUM_UNITS; j++) begin
         upper_req[j] = unit_valid[j] && (PW'(j) >= ptr);
      end
      for (int j = 0; j < NUM_UNITS; j++) begin
         if (!hit_hi && upper_req[j]) begin
            hit_hi = 1'b1;
            win_hi = PW'(j);
         end
         if (!hit_lo && unit_valid[j]) begin
            hit_lo = 1'b1;
            win_lo = PW'(j);
         end
      end
   end

   assign winner    = hit_hi ? win_hi : win_lo;
   assign grant_any = (hit_hi | hit_lo) & ~rst & ~init_clear;
   assign unit_ack  = grant_any ? (NUM_UNITS'(1) << winner) : '0;
   assign ptr_next  = (winner == PW'(NUM_UNITS - 1)) ? '0 : winner + PW'(1);

   assign winner_addr = unit_phys_addr[winner];
   assign winner_data = unit_data[winner];

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr              <= '0;
         commit_valid     <= 1'b0;
         commit_phys_addr <= '0;
         commit_data      <= '0;
      end else begin
         if (init_clear) begin
            ptr <= '0;
         end else if (grant_any) begin
            ptr <= ptr_next;
         end
         // Physical register 0 is hardwired: acked, but never written.
         commit_valid <= grant_any & (winner_addr != '0);
         if (grant_any) begin
            commit_phys_addr <= winner_addr;
            commit_data      <= winner_data;
         end
      end
   end

   assign inflight_commit      = commit_valid;
   assign inflight_commit_addr = commit_phys_addr;

endmodule
